// File: rtl/mem_port_arbiter.sv
// Arbitrates the instruction-fetch (IF) and load/store (D) ports onto one memory interface, with a WAIT watchdog.
// Optional macro ROUND_ROBIN_EN: on simultaneous requests the port that did not win last time wins.
module mem_port_arbiter #(
   parameter int TIMEOUT = 64,
   parameter int CNT_W   = 8
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        if_req,
   input  logic [12:0] if_address,
   output logic        if_grant,
   output logic [31:0] if_rdata,
   output logic        if_valid,
   input  logic        d_load,
   input  logic        d_store,
   input  logic [12:0] d_address,
   input  logic [31:0] d_wdata,
   input  logic [1:0]  d_word_type,
   input  logic        d_is_signed,
   output logic        d_grant,
   output logic [31:0] d_rdata,
   output logic        d_valid,
   output logic        d_write_done,
   output logic        err,
   output logic        mi_load,
   output logic        mi_store,
   output logic [12:0] mi_address,
   output logic [31:0] mi_data_in,
   output logic [1:0]  mi_word_type,
   output logic        mi_is_signed,
   input  logic [31:0] mi_data_out,
   input  logic        mi_output_valid,
   input  logic        mi_write_ready,
   input  logic        mi_busy
);

   typedef enum logic [1:0] {
      ST_IDLE   = 2'b00,
      ST_LAUNCH = 2'b01,
      ST_WAIT   = 2'b10
   } state_t;

   // Abort fires on the WAIT edge where the watchdog would step to TIMEOUT-1.
   localparam logic [CNT_W-1:0] WD_LAST = CNT_W'(TIMEOUT - 32'sd2);
   localparam logic [CNT_W-1:0] WD_ONE  = CNT_W'(32'sd1);

   state_t           state_r;
   logic [CNT_W-1:0] wdog_r;
   logic             win_d_r;
   logic             op_store_r;
   logic             last_winner_r;
   logic             d_req_s;
   logic             d_is_store_s;
   logic             d_wins_s;

   assign d_req_s      = d_load | d_store;
   assign d_is_store_s = d_store & ~d_load;

`ifdef ROUND_ROBIN_EN
   // Winner select: on contention the port that did not win last time goes first
   always_comb begin
      d_wins_s = 1'b0;
      if (d_req_s && if_req) begin
         d_wins_s = ~last_winner_r;
      end else begin
         d_wins_s = d_req_s;
      end
   end
`else
   logic unused_last_winner_s;
   assign unused_last_winner_s = last_winner_r;

   // Winner select: data port always beats instruction fetch
   always_comb begin
      d_wins_s = 1'b0;
      if (d_req_s) begin
         d_wins_s = 1'b1;
      end else begin
         d_wins_s = 1'b0;
      end
   end
`endif

   // Transfer sequencer with registered strobes, grants, completions and latched request fields
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_r       <= ST_IDLE;
         wdog_r        <= '0;
         win_d_r       <= 1'b0;
         op_store_r    <= 1'b0;
         last_winner_r <= 1'b0;
         if_grant      <= 1'b0;
         if_rdata      <= 32'h0;
         if_valid      <= 1'b0;
         d_grant       <= 1'b0;
         d_rdata       <= 32'h0;
         d_valid       <= 1'b0;
         d_write_done  <= 1'b0;
         err           <= 1'b0;
         mi_load       <= 1'b0;
         mi_store      <= 1'b0;
         mi_address    <= 13'h0;
         mi_data_in    <= 32'h0;
         mi_word_type  <= 2'b00;
         mi_is_signed  <= 1'b0;
      end else begin
         if_grant     <= 1'b0;
         d_grant      <= 1'b0;
         if_valid     <= 1'b0;
         d_valid      <= 1'b0;
         d_write_done <= 1'b0;
         err          <= 1'b0;
         mi_load      <= 1'b0;
         mi_store     <= 1'b0;
         case (state_r)
            ST_IDLE: begin
               if (!mi_busy && (d_req_s || if_req)) begin
                  state_r <= ST_LAUNCH;
                  win_d_r <= d_wins_s;
                  if (d_wins_s) begin
                     op_store_r   <= d_is_store_s;
                     mi_address   <= d_address;
                     mi_data_in   <= d_is_store_s ? d_wdata : 32'h0;
                     mi_word_type <= d_word_type;
                     mi_is_signed <= d_is_signed;
                     d_grant      <= 1'b1;
                     mi_load      <= ~d_is_store_s;
                     mi_store     <= d_is_store_s;
                     // Load and store together is treated as a load and flagged.
                     err          <= d_load & d_store;
                  end else begin
                     op_store_r   <= 1'b0;
                     mi_address   <= if_address;
                     mi_data_in   <= 32'h0;
                     mi_word_type <= 2'b10;
                     mi_is_signed <= 1'b0;
                     if_grant     <= 1'b1;
                     mi_load      <= 1'b1;
                  end
               end
            end
            ST_LAUNCH: begin
               state_r <= ST_WAIT;
               wdog_r  <= '0;
            end
            ST_WAIT: begin
               if (!op_store_r && mi_output_valid) begin
                  if (win_d_r) begin
                     d_rdata <= mi_data_out;
                     d_valid <= 1'b1;
                  end else begin
                     if_rdata <= mi_data_out;
                     if_valid <= 1'b1;
                  end
                  state_r       <= ST_IDLE;
                  last_winner_r <= win_d_r;
               end else if (op_store_r && mi_write_ready) begin
                  d_write_done  <= 1'b1;
                  state_r       <= ST_IDLE;
                  last_winner_r <= win_d_r;
               end else if (wdog_r == WD_LAST) begin
                  err           <= 1'b1;
                  state_r       <= ST_IDLE;
                  last_winner_r <= win_d_r;
               end else begin
                  wdog_r <= wdog_r + WD_ONE;
               end
            end
            default: begin
               state_r <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomised and directed bench for mem_port_arbiter against a transaction-level model timed in cycle numbers.
module tb_mem_port_arbiter;
   localparam int TO = 8;

   logic clk = 1'b0;
   logic reset;
   logic if_req, d_load, d_store, d_is_signed;
   logic [12:0] if_address, d_address;
   logic [31:0] d_wdata, mi_data_out;
   logic [1:0]  d_word_type;
   logic mi_output_valid, mi_write_ready, mi_busy;
   logic if_grant, if_valid, d_grant, d_valid, d_write_done, err, mi_load, mi_store, mi_is_signed;
   logic [31:0] if_rdata, d_rdata, mi_data_in;
   logic [12:0] mi_address;
   logic [1:0]  mi_word_type;

   always #5 clk = ~clk;

   mem_port_arbiter #(.TIMEOUT(TO), .CNT_W(8)) dut (
      .clk(clk), .reset(reset),
      .if_req(if_req), .if_address(if_address), .if_grant(if_grant), .if_rdata(if_rdata), .if_valid(if_valid),
      .d_load(d_load), .d_store(d_store), .d_address(d_address), .d_wdata(d_wdata),
      .d_word_type(d_word_type), .d_is_signed(d_is_signed), .d_grant(d_grant), .d_rdata(d_rdata),
      .d_valid(d_valid), .d_write_done(d_write_done), .err(err),
      .mi_load(mi_load), .mi_store(mi_store), .mi_address(mi_address), .mi_data_in(mi_data_in),
      .mi_word_type(mi_word_type), .mi_is_signed(mi_is_signed), .mi_data_out(mi_data_out),
      .mi_output_valid(mi_output_valid), .mi_write_ready(mi_write_ready), .mi_busy(mi_busy)
   );

   int checks = 0;
   int errors = 0;
   int cur_cyc = 0;

   // Model: one transaction in flight, described by its launch cycle and owner.
   bit m_act, m_wd, m_st, m_last_d;
   int m_launch;
   logic e_if_grant, e_d_grant, e_mi_load, e_mi_store, e_if_valid, e_d_valid, e_done, e_err;
   logic [12:0] e_addr;
   logic [31:0] e_wdata, e_if_rdata, e_d_rdata;
   logic [1:0]  e_wt;
   logic        e_sg;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s at cycle %0d: got %h, expected %h", name, cur_cyc, act, exp);
      end
   endtask

   task automatic clear_pulses();
      e_if_grant = 1'b0; e_d_grant = 1'b0; e_mi_load = 1'b0; e_mi_store = 1'b0;
      e_if_valid = 1'b0; e_d_valid = 1'b0; e_done = 1'b0; e_err = 1'b0;
   endtask

   task automatic model_reset();
      clear_pulses();
      m_act = 1'b0; m_wd = 1'b0; m_st = 1'b0; m_last_d = 1'b0; m_launch = 0;
      e_addr = 13'h0; e_wdata = 32'h0; e_wt = 2'b00; e_sg = 1'b0;
      e_if_rdata = 32'h0; e_d_rdata = 32'h0;
   endtask

   // Predicts the outputs of the cycle following the upcoming rising edge.
   task automatic model_step();
      bit dreq, wd;
      clear_pulses();
      if (!reset) begin
         model_reset();
      end else if (!m_act) begin
         dreq = d_load || d_store;
         if (!mi_busy && (dreq || if_req)) begin
            if (dreq && if_req) begin
`ifdef ROUND_ROBIN_EN
               wd = !m_last_d;
`else
               wd = 1'b1;
`endif
            end else begin
               wd = dreq;
            end
            m_act = 1'b1; m_wd = wd; m_launch = cur_cyc + 1;
            if (wd) begin
               m_st = d_store && !d_load;
               e_addr = d_address; e_wt = d_word_type; e_sg = d_is_signed;
               e_wdata = m_st ? d_wdata : 32'h0;
               e_d_grant = 1'b1; e_mi_load = !m_st; e_mi_store = m_st;
               e_err = d_load && d_store;
            end else begin
               m_st = 1'b0;
               e_addr = if_address; e_wt = 2'b10; e_sg = 1'b0; e_wdata = 32'h0;
               e_if_grant = 1'b1; e_mi_load = 1'b1;
            end
         end
      end else if (cur_cyc > m_launch) begin
         if (!m_st && mi_output_valid) begin
            if (m_wd) begin e_d_valid = 1'b1; e_d_rdata = mi_data_out; end
            else begin e_if_valid = 1'b1; e_if_rdata = mi_data_out; end
            m_act = 1'b0; m_last_d = m_wd;
         end else if (m_st && mi_write_ready) begin
            e_done = 1'b1; m_act = 1'b0; m_last_d = m_wd;
         end else if (cur_cyc - m_launch == TO - 1) begin
            e_err = 1'b1; m_act = 1'b0; m_last_d = m_wd;
         end
      end
   endtask

   task automatic compare();
      chk("pulses", {24'h0, if_grant, d_grant, mi_load, mi_store, if_valid, d_valid, d_write_done, err},
          {24'h0, e_if_grant, e_d_grant, e_mi_load, e_mi_store, e_if_valid, e_d_valid, e_done, e_err});
      chk("mi_address", 32'(mi_address), 32'(e_addr));
      chk("mi_data_in", mi_data_in, e_wdata);
      chk("mi_type", {29'h0, mi_word_type, mi_is_signed}, {29'h0, e_wt, e_sg});
      if (e_if_valid) chk("if_rdata", if_rdata, e_if_rdata);
      if (e_d_valid)  chk("d_rdata", d_rdata, e_d_rdata);
   endtask

   task automatic cycle_step();
      model_step();
      @(negedge clk);
      cur_cyc++;
      compare();
   endtask

   task automatic quiet_inputs();
      if_req = 1'b0; d_load = 1'b0; d_store = 1'b0;
      mi_output_valid = 1'b0; mi_write_ready = 1'b0; mi_busy = 1'b0;
   endtask

   task automatic drain();
      for (int i = 0; i < 60 && (m_act || if_req || d_load || d_store); i++) begin
         if (e_if_grant) if_req = 1'b0;
         if (e_d_grant) begin d_load = 1'b0; d_store = 1'b0; end
         mi_output_valid = 1'b1; mi_write_ready = 1'b1; mi_busy = 1'b0;
         cycle_step();
      end
      quiet_inputs();
      cycle_step();
   endtask

   task automatic all_zero(input string name);
      chk(name, {24'h0, if_grant, d_grant, mi_load, mi_store, if_valid, d_valid, d_write_done, err}, 32'h0);
      chk({name, "_fields"}, {17'h0, mi_address, mi_word_type}, 32'h0);
      chk({name, "_data"}, mi_data_in | if_rdata | d_rdata | {31'h0, mi_is_signed}, 32'h0);
   endtask

   initial begin
      #200000;
      $display("FAIL global_timeout: simulation did not complete");
      $fatal(1, "global timeout");
   end

   initial begin
      reset = 1'b0;
      quiet_inputs();
      if_address = 13'h0; d_address = 13'h0; d_wdata = 32'h0; d_word_type = 2'b00;
      d_is_signed = 1'b0; mi_data_out = 32'h0;
      model_reset();
      cycle_step();
      cycle_step();
      all_zero("reset_state");
      reset = 1'b1;
      cycle_step();

      // Instruction fetch, completion three cycles after the strobe.
      if_req = 1'b1; if_address = 13'h0040;
      cycle_step();
      chk("if_grant_strobe", {30'h0, if_grant, mi_load}, 32'h3);
      chk("if_addr", 32'(mi_address), 32'h40);
      chk("if_wtype", {29'h0, mi_word_type, mi_is_signed}, 32'h4);
      if_req = 1'b0;
      cycle_step(); cycle_step();
      mi_output_valid = 1'b1; mi_data_out = 32'hDEADBEEF;
      cycle_step();
      chk("if_valid", 32'(if_valid), 32'h1);
      chk("if_rdata_lit", if_rdata, 32'hDEADBEEF);
      mi_output_valid = 1'b0;
      cycle_step();
      chk("if_valid_pulse", 32'(if_valid), 32'h0);

      // Halfword store; a stray load-complete during the store is ignored.
      d_store = 1'b1; d_address = 13'h0102; d_wdata = 32'h12345678; d_word_type = 2'b01; d_is_signed = 1'b0;
      cycle_step();
      chk("st_grant_strobe", {29'h0, d_grant, mi_store, mi_load}, 32'h6);
      d_store = 1'b0;
      mi_output_valid = 1'b1;
      cycle_step();
      mi_output_valid = 1'b0;
      for (int k = 0; k < 3; k++) begin
         cycle_step();
         chk("st_hold_data", mi_data_in, 32'h12345678);
         chk("st_no_valid", {30'h0, d_valid, d_write_done}, 32'h0);
      end
      mi_write_ready = 1'b1;
      cycle_step();
      chk("st_done", 32'(d_write_done), 32'h1);
      mi_write_ready = 1'b0;
      cycle_step();

      // Contention: D first, then IF, then D again on a third simultaneous request.
      if_req = 1'b1; if_address = 13'h00AA; d_load = 1'b1; d_address = 13'h0155; d_word_type = 2'b10;
      cycle_step();
      chk("arb1_d", {30'h0, d_grant, if_grant}, 32'h2);
      d_load = 1'b0;
      cycle_step();
      mi_output_valid = 1'b1; mi_data_out = 32'h00001111;
      cycle_step();
      mi_output_valid = 1'b0;
      cycle_step();
      chk("arb2_if", {30'h0, d_grant, if_grant}, 32'h1);
      if_req = 1'b0;
      cycle_step();
      mi_output_valid = 1'b1;
      cycle_step();
      mi_output_valid = 1'b0;
      if_req = 1'b1; d_load = 1'b1;
      cycle_step();
      chk("arb3_d", {30'h0, d_grant, if_grant}, 32'h2);
      drain();

      // Unanswered byte load times out.
      d_load = 1'b1; d_address = 13'h01F0; d_word_type = 2'b00; d_is_signed = 1'b1;
      cycle_step();
      chk("to_grant", 32'(d_grant), 32'h1);
      d_load = 1'b0;
      for (int k = 1; k < TO; k++) begin
         cycle_step();
         chk("to_no_early_err", 32'(err), 32'h0);
      end
      cycle_step();
      chk("to_err", {30'h0, err, d_valid}, 32'h2);
      cycle_step();
      chk("to_err_pulse", 32'(err), 32'h0);

      // Busy interface holds off arbitration.
      mi_busy = 1'b1; if_req = 1'b1; if_address = 13'h0777;
      for (int k = 0; k < 5; k++) begin
         cycle_step();
         chk("busy_no_grant", 32'(if_grant), 32'h0);
      end
      mi_busy = 1'b0;
      cycle_step();
      chk("busy_grant", 32'(if_grant), 32'h1);
      drain();

      // Reset in WAIT aborts silently; a late completion is ignored.
      if_req = 1'b1; if_address = 13'h0123;
      cycle_step();
      if_req = 1'b0;
      cycle_step(); cycle_step();
      reset = 1'b0;
      model_reset();
      #1;
      all_zero("reset_mid");
      cycle_step(); cycle_step();
      reset = 1'b1;
      mi_output_valid = 1'b1; mi_data_out = 32'hCAFEF00D;
      cycle_step();
      chk("post_reset_quiet", {29'h0, if_valid, d_valid, err}, 32'h0);
      mi_output_valid = 1'b0;
      cycle_step(); cycle_step();

      // Randomised traffic against the model.
      for (int n = 0; n < 3000; n++) begin
         if (e_if_grant) if_req = 1'b0;
         if (e_d_grant) begin d_load = 1'b0; d_store = 1'b0; end
         if (!if_req && ($urandom % 3 == 0)) begin
            if_req = 1'b1; if_address = 13'($urandom);
         end
         if (!d_load && !d_store && ($urandom % 3 == 0)) begin
            case ($urandom % 10)
               0: begin d_load = 1'b1; d_store = 1'b1; end
               1, 2, 3, 4: d_store = 1'b1;
               default: d_load = 1'b1;
            endcase
            d_address = 13'($urandom); d_wdata = $urandom;
            d_word_type = 2'($urandom_range(2, 0)); d_is_signed = 1'($urandom);
         end
         mi_busy = ($urandom % 8 == 0);
         mi_output_valid = ($urandom % 5 == 0);
         mi_write_ready = ($urandom % 5 == 0);
         mi_data_out = $urandom;
         cycle_step();
      end
      drain();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single CPU-side memory interface between two requesters: the instruction-fetch port (IF) and the load/store data port (D).
- Accepts one request at a time, latches its address, data and type fields, and launches it to the interface with a one-cycle load/store strobe.
- Waits for the completion handshake, returns data or a write acknowledge to the winning requester, then re-arbitrates.
- Sits between the CPU pipeline and the memory interface; it has a watchdog against a hung transfer.

Parameters:
- TIMEOUT, 64: maximum WAIT cycles before abort; range 2..255.
- CNT_W, 8: width of the watchdog counter.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- if_req  input  1  instruction fetch request; held until if_grant.
- if_address  input  13  fetch byte address.
- if_grant  output  1  one-cycle pulse: IF request accepted.
- if_rdata  output  32  fetched word; valid only while if_valid is high.
- if_valid  output  1  one-cycle pulse: if_rdata valid.
- d_load  input  1  data load request; held until d_grant.
- d_store  input  1  data store request; held until d_grant.
- d_address  input  13  data byte address.
- d_wdata  input  32  store data.
- d_word_type  input  2  2'b00 byte, 2'b01 halfword, 2'b10 word.
- d_is_signed  input  1  sign-extend loads.
- d_grant  output  1  one-cycle pulse: D request accepted.
- d_rdata  output  32  load result; valid only while d_valid is high.
- d_valid  output  1  one-cycle pulse: d_rdata valid.
- d_write_done  output  1  one-cycle pulse: store completed.
- err  output  1  one-cycle pulse: timeout or protocol error.
- mi_load  output  1  load strobe to the interface.
- mi_store  output  1  store strobe to the interface.
- mi_address  output  13  latched address.
- mi_data_in  output  32  latched store data.
- mi_word_type  output  2  latched type.
- mi_is_signed  output  1  latched signedness.
- mi_data_out  input  32  interface read data.
- mi_output_valid  input  1  interface load-complete pulse.
- mi_write_ready  input  1  interface store-complete pulse.
- mi_busy  input  1  interface busy.

Behaviour:
Reset values:
- All outputs are 0; state is IDLE; the latched field registers are 0.
- last_winner resets to IF.
- Reset asserted mid-transfer aborts the transfer silently, with no valid, done or err pulse.

States: IDLE, LAUNCH, WAIT.
- IDLE → LAUNCH: on a clock edge where mi_busy=0 and any request is present.
  - Select the winner.
  - Latch mi_address, mi_data_in, mi_word_type, mi_is_signed and the op (load or store).
  - IF requests always latch word_type 2'b10 and is_signed 0.
  - mi_data_in is 0 for any load.
- IDLE with mi_busy=1: hold in IDLE. No grant is issued.
- LAUNCH: lasts exactly 1 cycle.
  - The winner's grant is high.
  - mi_load or mi_store is high according to the latched op.
  - Next state is WAIT; the watchdog is cleared to 0.
- WAIT:
  - mi_load and mi_store are 0; the mi_* field outputs stay stable.
  - The watchdog increments each cycle.
  - Load op with mi_output_valid=1: register mi_data_out into the winner's rdata and pulse the winner's valid on the next cycle. Next state IDLE; update last_winner.
  - Store op with mi_write_ready=1: pulse d_write_done on the next cycle. Next state IDLE; update last_winner.
  - Watchdog reaches TIMEOUT−1 with no completion: pulse err, return to IDLE, update last_winner. The requester receives no valid or done pulse.
- Completion pulses ignored:
  - mi_output_valid during a store op.
  - mi_write_ready during a load op.
  - Either completion pulse while in IDLE or LAUNCH.

Latency:
- Request sampled at edge N → grant and strobe during cycle N+1.
- Completion at edge M → valid or done during cycle M+1.
- Minimum gap between two consecutive launches is 3 cycles.

Arbitration:
- Default is fixed priority: D beats IF.
- A request arriving while the arbiter is not in IDLE waits; it is not lost, because requesters hold their requests.

Protocol error:
- d_load and d_store high together at arbitration: treat as a load and pulse err in the LAUNCH cycle.

Optional Feature:
- ROUND_ROBIN_EN defined: when IF and D request in the same arbitration cycle, the port that is not last_winner wins. A single requester always wins.
- ROUND_ROBIN_EN undefined: fixed D-over-IF priority. last_winner is still tracked but unused.

Test Plan:
- if_req=1, if_address=13'h0040, mi_output_valid pulsed with mi_data_out=32'hDEADBEEF 3 cycles after the strobe → if_grant and mi_load in the same cycle, mi_address=13'h0040, mi_word_type=2'b10, then if_valid=1 with if_rdata=32'hDEADBEEF for one cycle.
- d_store=1, d_address=13'h0102, d_wdata=32'h12345678, d_word_type=2'b01 → d_grant and mi_store together; mi_data_in=32'h12345678 held through WAIT; mi_write_ready → d_write_done one cycle later.
- if_req and d_load raised in the same cycle, twice in succession → fixed priority: D, then IF on the next arbitration. With ROUND_ROBIN_EN after reset: D first, then IF; a third simultaneous request goes to D.
- d_load=1 with no completion pulse, TIMEOUT=8 → err pulses 8 cycles after the LAUNCH cycle, state returns to IDLE, and no d_valid is seen.
- mi_busy=1 with if_req=1 for 5 cycles, then mi_busy=0 → no if_grant while mi_busy is high; if_grant arrives one cycle after mi_busy falls.
- reset pulled low during WAIT of a load, then a completion pulse arrives after reset is released → all outputs 0 immediately, and no if_valid, d_valid or err follows.
